// File: rtl/pipeline_exception_ctrl_pkg.sv
// Shared definitions for the exception controller: exception word layout,
// cause width and FSM state encoding.
package pipeline_exception_ctrl_pkg;

  localparam int unsigned EXC_W   = 10;
  localparam int unsigned CAUSE_W = 4;

  // final_exception = {fetch[2:0], decode, alu[2:0], mem[2:0]}
  localparam int unsigned EXC_MEM_LSB    = 0;
  localparam int unsigned EXC_ALU_LSB    = 3;
  localparam int unsigned EXC_DECODE_BIT = 6;
  localparam int unsigned EXC_FETCH_LSB  = 7;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE   = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_MEM0   = 4'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_FETCH2 = 4'd10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FLUSH    = 3'd1;
  localparam logic [2:0] ST_REPORT   = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_REDIRECT = 3'd4;

endpackage

// File: rtl/pipeline_exception_ctrl_if.sv
// Host-side report/resume handshake of the exception controller.
interface pipeline_exception_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  import pipeline_exception_ctrl_pkg::*;

  logic               report_valid;
  logic               report_ready;
  logic [XLEN-1:0]    epc;
  logic [XLEN-1:0]    badaddr;
  logic [CAUSE_W-1:0] cause;
  logic               resume_valid;
  logic [XLEN-1:0]    resume_pc;
  logic               resume_ready;

  modport master (
    input  report_valid, epc, badaddr, cause, resume_ready,
    output report_ready, resume_valid, resume_pc
  );

  modport slave (
    output report_valid, epc, badaddr, cause, resume_ready,
    input  report_ready, resume_valid, resume_pc
  );
endinterface

// File: rtl/pipeline_exception_ctrl_cause_enc.sv
// Priority encoder: highest set exception bit i yields cause i+1, zero means none.
module exc_cause_enc
  import pipeline_exception_ctrl_pkg::*;
(
  input  logic [EXC_W-1:0]   final_exception,
  output logic [CAUSE_W-1:0] cause
);

  // Ascending scan so the highest set bit (fetch side) wins.
  always_comb begin
    cause = CAUSE_NONE;
    for (int unsigned i = 0; i < EXC_W; i++) begin
      if (final_exception[i]) cause = CAUSE_W'(i + 1);
    end
  end

endmodule

// File: rtl/pipeline_exception_ctrl.sv
// Exception controller: captures the sticky exception word, flushes the pipe,
// reports to the host, waits for a resume PC and redirects fetch.
module pipeline_exception_ctrl
  import pipeline_exception_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned XLEN         = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [EXC_W-1:0]          final_exception,
  input  logic [XLEN-1:0]           exc_pc,
  input  logic [XLEN-1:0]           exc_badaddr,
  output logic                      flush,
  output logic                      busy,
  output logic                      redirect_valid,
  output logic [XLEN-1:0]           redirect_pc,
  output logic                      exc_clear,
  pipeline_exception_ctrl_if.slave  host
);

  logic [2:0]         state;
  logic [3:0]         cnt;
  logic               holdoff;
  logic [CAUSE_W-1:0] cause_enc;
  logic [CAUSE_W-1:0] cause_q;
  logic [XLEN-1:0]    epc_q;
  logic [XLEN-1:0]    badaddr_q;
  logic [XLEN-1:0]    redirect_pc_q;

  exc_cause_enc u_cause_enc (
    .final_exception (final_exception),
    .cause           (cause_enc)
  );

  // holdoff masks the first IDLE cycle after REDIRECT, while the regwrite
  // sticky latch is still being cleared by exc_clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      holdoff       <= 1'b0;
      cause_q       <= '0;
      epc_q         <= '0;
      badaddr_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          holdoff <= 1'b0;
          if ((final_exception != '0) && !holdoff) begin
            epc_q     <= exc_pc;
            badaddr_q <= exc_badaddr;
            cause_q   <= cause_enc;
            cnt       <= 4'(FLUSH_CYCLES - 1);
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) state <= ST_REPORT;
          else           cnt   <= cnt - 4'd1;
        end
        ST_REPORT: begin
          if (host.report_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (host.resume_valid) begin
            redirect_pc_q <= host.resume_pc & ~XLEN'(3);
            state         <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          holdoff <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign flush             = (state == ST_FLUSH);
  assign busy              = (state != ST_IDLE);
  assign redirect_valid    = (state == ST_REDIRECT);
  assign exc_clear         = (state == ST_REDIRECT);
  assign redirect_pc       = redirect_pc_q;
  assign host.report_valid = (state == ST_REPORT);
  assign host.resume_ready = (state == ST_WAIT);
  assign host.epc          = epc_q;
  assign host.badaddr      = badaddr_q;
  assign host.cause        = cause_q;

endmodule
